// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and width helper for the 8N1 UART receiver.
package uart_rx_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  function automatic int myclog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial inputs and byte handshake; master = receiver, slave = consumer.
interface uart_rx_if #(parameter int DATA_BITS = uart_rx_pkg::DATA_BITS_DEF);

  logic                 rxclk_en;
  logic                 rx;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rxclk_en, rx, rdy_clr,
    output data, rdy, frame_err, overrun, busy
  );

  modport slave (
    output rxclk_en, rx, rdy_clr,
    input  data, rdy, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency.
// Reset loads RST_VAL into both flops so an idle line does not look like an edge.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the oversample strobe; rdy rises 1 clk after the mid-stop tick.
// No backpressure: a byte completing while rdy is still set raises overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic      clk_50m,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int SAMP_W = myclog2(OVERSAMPLE);
  localparam int BIT_W  = myclog2(DATA_BITS);

  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  state_t               state_q, state_nxt;
  logic [SAMP_W-1:0]    sample_q, sample_nxt;
  logic [BIT_W-1:0]     bitidx_q, bitidx_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 rdy_q, rdy_nxt;
  logic                 frame_err_q, frame_err_nxt;
  logic                 overrun_q, overrun_nxt;

  bit_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sample_q    <= sample_nxt;
      bitidx_q    <= bitidx_nxt;
      shift_q     <= shift_nxt;
      data_q      <= data_nxt;
      rdy_q       <= rdy_nxt;
      frame_err_q <= frame_err_nxt;
      overrun_q   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    sample_nxt    = sample_q;
    bitidx_nxt    = bitidx_q;
    shift_nxt     = shift_q;
    data_nxt      = data_q;
    rdy_nxt       = rdy_q;
    frame_err_nxt = frame_err_q;
    overrun_nxt   = overrun_q;

    // Clear first so that a same-cycle completion below takes priority.
    if (bus.rdy_clr) begin
      rdy_nxt       = 1'b0;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;
    end

    if (bus.rxclk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt  = ST_START;
            sample_nxt = '0;
          end
        end
        ST_START: begin
          if (sample_q == SAMP_MID) begin
            if (!rx_s) begin
              state_nxt  = ST_DATA;
              sample_nxt = '0;
              bitidx_nxt = '0;
            end else begin
              state_nxt  = ST_IDLE;
            end
          end else begin
            sample_nxt = sample_q + SAMP_W'(1);
          end
        end
        ST_DATA: begin
          if (sample_q == SAMP_LAST) begin
            shift_nxt  = {rx_s, shift_q[DATA_BITS-1:1]};
            sample_nxt = '0;
            if (bitidx_q == BIT_LAST) state_nxt  = ST_STOP;
            else                      bitidx_nxt = bitidx_q + BIT_W'(1);
          end else begin
            sample_nxt = sample_q + SAMP_W'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (sample_q == SAMP_LAST) begin
            state_nxt = ST_IDLE;
            if (rx_s) begin
              data_nxt = shift_q;
              rdy_nxt  = 1'b1;
              if (rdy_q && !bus.rdy_clr) overrun_nxt = 1'b1;
            end else begin
              frame_err_nxt = 1'b1;
            end
          end else begin
            sample_nxt = sample_q + SAMP_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Consumes the 16x-oversampled rxclk_en strobe from the shared baud rate generator and the asynchronous serial input line.
- Recovers each byte, presents it on a ready/clear handshake, and flags framing and overrun errors.
- Sits beside the UART transmitter in the serial block, on the 50 MHz system clock domain.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, rxclk_en ticks per bit; must be a power of two and at least 8.

Ports:
- clk_50m  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rxclk_en  input  1  one-cycle oversample strobe, OVERSAMPLE ticks per bit.
- rx  input  1  asynchronous serial line; idles high.
- rdy_clr  input  1  one-cycle pulse that consumes the byte and clears rdy, overrun and frame_err.
- data  output  DATA_BITS  last good byte received.
- rdy  output  1  a byte is available (sticky).
- frame_err  output  1  stop bit sampled low (sticky).
- overrun  output  1  byte completed while rdy was already 1 (sticky).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset is synchronous and active-high. It sets:
  - state IDLE; sample and bit counters 0; shift register 0;
  - data 0, rdy 0, frame_err 0, overrun 0, busy 0;
  - both synchronizer flops to 1.
- Asserting rst mid-frame discards the partial byte. The line is re-acquired on the next falling edge.
- rx passes through a 2-flop synchronizer clocked every clk_50m cycle (not gated). rx_s is the synchronized value.
- State and counters advance only on cycles with rxclk_en=1. Exceptions: rst, and the rdy_clr clearing logic, which run every cycle.
- IDLE:
  - tick with rx_s=0 -> START, sample<=0.
  - otherwise stay in IDLE.
- START:
  - tick with sample==OVERSAMPLE/2-1 (mid-bit): if rx_s=0 -> DATA, sample<=0, bitidx<=0. If rx_s=1 -> IDLE (glitch rejected, no flags set).
  - other ticks: sample<=sample+1.
- DATA:
  - tick with sample==OVERSAMPLE-1: shift<={rx_s, shift[DATA_BITS-1:1]}, sample<=0. If bitidx==DATA_BITS-1 -> STOP, else bitidx<=bitidx+1.
  - other ticks: sample<=sample+1.
- STOP:
  - tick with sample==OVERSAMPLE-1 (mid stop bit): -> IDLE.
    - If rx_s=1: data<=shift, rdy<=1. If rdy was 1 and rdy_clr=0 in the same cycle, also overrun<=1.
    - If rx_s=0: frame_err<=1; data and rdy unchanged.
  - other ticks: sample<=sample+1.
  - Returning to IDLE at mid stop bit allows back-to-back frames.
- rdy_clr=1 clears rdy, overrun and frame_err on the next edge. If a set event occurs in the same cycle, the set wins.
- Counters wrap only through the explicit compares above; the sample counter never exceeds OVERSAMPLE-1.
- Latency: rdy rises 1 clk after the rxclk_en tick at mid stop bit.
- With the standard generator (tick every 28 clk), one bit is 448 clk and rdy rises at about 9.5 bit times after the start edge.
- A continuously low line (break): the start bit validates, data bits shift in as 0, frame_err is set at the stop bit, then the block re-arms. A line still low at IDLE starts a new frame.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3;
  - OVERSAMPLE and DATA_BITS defaults;
  - counter widths derived with myclog2.
- One sub-module, bit_sync: 2-flop synchronizer with a reset value parameter (1 here). It is reused by other asynchronous inputs.

Test Plan:
- In all scenarios the bench pulses rxclk_en every 28 clk; bit = 448 clk.
- Send 0x55 (start, 1,0,1,0,1,0,1,0, stop) -> rdy=1 about 4256 clk after the start edge; data=0x55, frame_err=0, overrun=0, busy=0 after.
- Pulse rdy_clr, then send 0xA3 and 0x3C back-to-back, clearing rdy between them -> rdy=0 the cycle after clear; data=0xA3 then 0x3C; no error flags.
- Drive rx low for 3 ticks (84 clk), then high -> busy goes 1 then returns 0; rdy, frame_err and data unchanged.
- Send 0x0F with stop bit driven 0 -> frame_err=1, rdy=0, data keeps its prior value; rdy_clr clears frame_err.
- Send 0x12 then 0x34 without rdy_clr -> data=0x34, rdy=1, overrun=1. Repeat with rdy_clr asserted on the completion cycle of 0x34 -> overrun=0, rdy=1.
- Assert rst for 1 clk after 4 data bits of 0xFF, then send 0xC6 -> all outputs 0 after reset; data=0xC6, rdy=1, no error flags.
